rec_playback: RTL and testbench
===============================

// Module: rec_playback
// PURPOSE
//   Record-then-play audio buffer, the write-then-read counterpart of the mic delay path.
//   - RECORD: captures a burst of mic_signal samples into internal dual-port RAM.
//   - PLAY: streams the same burst back out on command, once or looped.
//   - Sits between the mic ADC sample path and the DAC/display output.
//   - Control comes from the top-level button/vbd logic.
// PARAMETERS
//   A_WIDTH  9  RAM address width; depth = 2**A_WIDTH samples
//   D_WIDTH  8  sample width
// PORTS
//   clk          in   1        single system clock, rising edge
//   rst          in   1        reset, synchronous, active-high
//   sample_en    in   1        sample strobe; one sample moved per strobe cycle
//   rec_start    in   1        start recording (sampled in IDLE only)
//   play_start   in   1        start playback (sampled in IDLE only)
//   stop         in   1        abort current RECORD/PLAY
//   loop_en      in   1        playback wraps to sample 0 at end of burst while high
//   rec_len      in   A_WIDTH  burst length in samples; 0 means full depth 2**A_WIDTH
//   mic_signal   in   D_WIDTH  sample to record
//   play_signal  out  D_WIDTH  played-back sample; holds last value when play_valid=0
//   play_valid   out  1        play_signal carries a new sample this cycle
//   busy         out  1        high in RECORD or PLAY
//   done         out  1        1-cycle pulse on any return to IDLE from RECORD/PLAY
// BEHAVIOUR
//   Reset:
//     - state=IDLE; addr=0; count=0; stored_len=0.
//     - play_signal=0; play_valid=0; busy=0; done=0.
//     - RAM contents are not cleared.
//   Counters:
//     - addr is A_WIDTH bits.
//     - count and stored_len are A_WIDTH+1 bits; stored_len max 2**A_WIDTH.
//   IDLE:
//     - rec_start=1: go to RECORD; addr=0; count=0; latch len = (rec_len==0) ? 2**A_WIDTH : rec_len.
//     - else play_start=1 and stored_len!=0: go to PLAY; addr=0; count=0.
//     - play_start with stored_len==0 is ignored.
//     - rec_start and play_start together: rec_start wins.
//     - sample_en is ignored.
//   RECORD, on each sample_en cycle:
//     - RAM[addr] <= mic_signal; addr++; count++.
//     - When count reaches len: stored_len=len; go to IDLE; pulse done.
//   PLAY, on each sample_en cycle:
//     - Issue read of RAM[addr]; addr++; count++.
//     - Read latency 1 cycle: play_valid=1 and play_signal=data on the cycle after the strobe.
//     - play_valid is otherwise 0.
//     - At count==stored_len with loop_en=1: addr=0, count=0; stay in PLAY, no gap in the sample stream.
//     - At count==stored_len with loop_en=0: go to IDLE.
//       - The last read's play_valid still fires the following cycle.
//       - done pulses in that same cycle.
//   stop (RECORD or PLAY):
//     - IDLE next cycle; done pulses; stop has priority over sample_en in the same cycle.
//     - In RECORD: stored_len = samples written so far. Abort with 0 written -> stored_len=0.
//     - In PLAY: an outstanding read still produces its play_valid.
//   Start strobes in RECORD/PLAY are ignored. Mid-operation rst returns to IDLE, reset values as above.
//   busy is a registered copy of (state != IDLE).
// TESTING
//   1. rst; rec_len=4; rec_start; 4 strobes with mic 0x10,0x20,0x30,0x40
//      -> done pulses after 4th strobe; busy low.
//   2. After 1, play_start, loop_en=0, 4 strobes
//      -> play_valid x4 with 0x10,0x20,0x30,0x40, each 1 cycle after its strobe; done with last.
//   3. After 1, loop_en=1, 6 strobes back-to-back
//      -> 0x10,0x20,0x30,0x40,0x10,0x20; busy stays 1.
//   4. rec_len=0, A_WIDTH=3; 8 strobes of ramp 0..7
//      -> stored_len=8; playback gives 0..7; 9th strobe absent, no wrap.
//   5. RECORD rec_len=10; stop after 3 strobes
//      -> IDLE next cycle; done; playback yields exactly 3 samples.
//   6. After reset, play_start -> stays IDLE, busy=0.
//      rec_start+play_start same cycle -> RECORD.
//      rst mid-PLAY -> play_valid=0, play_signal=0 next cycle.

Source files
------------

// File: rtl/rec_playback.sv
// Record-then-play sample buffer: captures a burst of mic samples into on-chip RAM
// and streams it back on command, once or looped.
module rec_playback #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_en,
    input  logic               rec_start,
    input  logic               play_start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [A_WIDTH-1:0] rec_len,
    input  logic [D_WIDTH-1:0] mic_signal,
    output logic [D_WIDTH-1:0] play_signal,
    output logic               play_valid,
    output logic               busy,
    output logic               done
);

    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] FULL_LEN = {1'b1, {A_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        PLAY
    } state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [A_WIDTH:0]   count_q, count_d;
    logic [A_WIDTH:0]   len_q, len_d;
    logic [A_WIDTH:0]   stored_len_q, stored_len_d;
    logic [A_WIDTH:0]   count_inc;
    logic               done_d, busy_d;
    logic               wr_en, rd_en;
    logic [D_WIDTH-1:0] play_signal_q;
    logic               play_valid_q, busy_q, done_q;

    logic [D_WIDTH-1:0] mem [DEPTH];

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        len_d        = len_q;
        stored_len_d = stored_len_q;
        wr_en        = 1'b0;
        rd_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (rec_start) begin
                    state_d = RECORD;
                    addr_d  = '0;
                    count_d = '0;
                    len_d   = (rec_len == '0) ? FULL_LEN : {1'b0, rec_len};
                end else if (play_start && stored_len_q != '0) begin
                    state_d = PLAY;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            RECORD: begin
                // An aborted recording keeps exactly the samples written so far
                if (stop) begin
                    state_d      = IDLE;
                    stored_len_d = count_q;
                end else if (sample_en) begin
                    wr_en   = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d      = IDLE;
                        stored_len_d = len_q;
                    end
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (sample_en) begin
                    rd_en   = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    count_d = count_inc;
                    if (count_inc == stored_len_q) begin
                        if (loop_en) begin
                            addr_d  = '0;
                            count_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_q != IDLE) && (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            len_q         <= '0;
            stored_len_q  <= '0;
            play_signal_q <= '0;
            play_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            len_q        <= len_d;
            stored_len_q <= stored_len_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            play_valid_q <= rd_en;
            if (rd_en) begin
                play_signal_q <= mem[addr_q];
            end
        end
    end

    // Sample storage survives reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q] <= mic_signal;
        end
    end

    assign play_signal = play_signal_q;
    assign play_valid  = play_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rec_playback.sv
// Directed self-checking bench for rec_playback with a 16-deep, 8-bit buffer.
module tb_rec_playback;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_en;
    logic       rec_start;
    logic       play_start;
    logic       stop;
    logic       loop_en;
    logic [3:0] rec_len;
    logic [7:0] mic_signal;
    logic [7:0] play_signal;
    logic       play_valid;
    logic       busy;
    logic       done;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] burst1 [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] burst5 [3] = '{8'hA1, 8'hA2, 8'hA3};

    rec_playback #(.A_WIDTH(4), .D_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .loop_en    (loop_en),
        .rec_len    (rec_len),
        .mic_signal (mic_signal),
        .play_signal(play_signal),
        .play_valid (play_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change just after an edge; outputs are sampled 1 time unit after the edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; rec_start = 1'b0; play_start = 1'b0;
        stop = 1'b0; loop_en = 1'b0; rec_len = 4'd0; mic_signal = 8'h00;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_play_signal", play_signal, 8'h00);
        checkOutput("rst_play_valid", play_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        rst = 1'b0;

        // Record four samples
        rec_len = 4'd4; rec_start = 1'b1;
        applyStimulus();
        rec_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_en = 1'b1; mic_signal = burst1[i];
            applyStimulus();
            if (i == 0) checkOutput("rec1_busy", busy, 1'b1);
            if (i == 2) checkOutput("rec1_done_early", done, 1'b0);
            if (i == 3) checkOutput("rec1_done", done, 1'b1);
        end
        sample_en = 1'b0;
        applyStimulus();
        checkOutput("rec1_idle_busy", busy, 1'b0);
        checkOutput("rec1_done_pulse", done, 1'b0);

        // Single playback
        loop_en = 1'b0; play_start = 1'b1;
        applyStimulus();
        play_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_en = 1'b1;
            applyStimulus();
            checkOutput("play1_valid", play_valid, 1'b1);
            checkOutput("play1_data", play_signal, burst1[i]);
            if (i == 2) checkOutput("play1_done_early", done, 1'b0);
            if (i == 3) checkOutput("play1_done", done, 1'b1);
        end
        sample_en = 1'b0;
        applyStimulus();
        checkOutput("play1_valid_low", play_valid, 1'b0);
        checkOutput("play1_hold", play_signal, 8'h40);
        checkOutput("play1_busy", busy, 1'b0);

        // Looped playback, six back-to-back strobes
        play_start = 1'b1;
        applyStimulus();
        play_start = 1'b0; loop_en = 1'b1; sample_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("loop_valid", play_valid, 1'b1);
            checkOutput("loop_data", play_signal, burst1[i % 4]);
            checkOutput("loop_busy", busy, 1'b1);
        end
        stop = 1'b1;
        applyStimulus();
        checkOutput("loop_stop_done", done, 1'b1);
        checkOutput("loop_stop_no_read", play_valid, 1'b0);
        stop = 1'b0; sample_en = 1'b0; loop_en = 1'b0;
        applyStimulus();
        checkOutput("loop_stop_busy", busy, 1'b0);

        // Full-depth recording via rec_len = 0
        rec_len = 4'd0; rec_start = 1'b1;
        applyStimulus();
        rec_start = 1'b0; sample_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mic_signal = 8'(i);
            applyStimulus();
            if (i == 14) checkOutput("full_rec_done_early", done, 1'b0);
            if (i == 15) checkOutput("full_rec_done", done, 1'b1);
        end
        sample_en = 1'b0;
        applyStimulus();
        play_start = 1'b1;
        applyStimulus();
        play_start = 1'b0; sample_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            checkOutput("full_play_data", play_signal, 8'(i));
            if (i == 15) checkOutput("full_play_done", done, 1'b1);
        end
        applyStimulus();
        checkOutput("full_no_wrap_valid", play_valid, 1'b0);
        checkOutput("full_no_wrap_hold", play_signal, 8'h0F);
        checkOutput("full_no_wrap_busy", busy, 1'b0);
        sample_en = 1'b0;

        // Aborted recording keeps three samples
        rec_len = 4'd10; rec_start = 1'b1;
        applyStimulus();
        rec_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_en = 1'b1; mic_signal = burst5[i];
            applyStimulus();
        end
        stop = 1'b1; mic_signal = 8'hEE;
        applyStimulus();
        checkOutput("abort_done", done, 1'b1);
        stop = 1'b0; sample_en = 1'b0;
        applyStimulus();
        checkOutput("abort_busy", busy, 1'b0);
        play_start = 1'b1;
        applyStimulus();
        play_start = 1'b0; sample_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("abort_play_data", play_signal, burst5[i]);
            if (i == 2) checkOutput("abort_play_done", done, 1'b1);
        end
        applyStimulus();
        checkOutput("abort_play_len", play_valid, 1'b0);
        sample_en = 1'b0;

        // Playback with nothing stored is ignored
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0; play_start = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("empty_play_busy", busy, 1'b0);
        play_start = 1'b0; sample_en = 1'b1;
        applyStimulus();
        checkOutput("empty_play_valid", play_valid, 1'b0);
        sample_en = 1'b0;

        // Simultaneous starts record
        rec_len = 4'd2; rec_start = 1'b1; play_start = 1'b1;
        applyStimulus();
        rec_start = 1'b0; play_start = 1'b0; sample_en = 1'b1; mic_signal = 8'h77;
        applyStimulus();
        checkOutput("both_start_valid", play_valid, 1'b0);
        checkOutput("both_start_busy", busy, 1'b1);
        mic_signal = 8'h88;
        applyStimulus();
        checkOutput("both_start_done", done, 1'b1);
        sample_en = 1'b0;
        applyStimulus();

        // Reset in the middle of playback
        play_start = 1'b1;
        applyStimulus();
        play_start = 1'b0; sample_en = 1'b1;
        applyStimulus();
        checkOutput("mid_play_data", play_signal, 8'h77);
        rst = 1'b1;
        applyStimulus();
        checkOutput("mid_rst_valid", play_valid, 1'b0);
        checkOutput("mid_rst_signal", play_signal, 8'h00);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_done", done, 1'b0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("after_rst_valid", play_valid, 1'b0);
        sample_en = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
